// File: rtl/conv_encode_core_if.sv
// Payload stream bundle for conv_encode_core: 8-bit input byte stream and coded output byte stream.
interface conv_encode_core_if;
  logic [7:0] s_in_payload_tdata;
  logic       s_in_payload_tkeep;
  logic       s_in_payload_tlast;
  logic       s_in_payload_tvalid;
  logic       s_in_payload_tready;

  logic [7:0] m_out_payload_tdata;
  logic       m_out_payload_tkeep;
  logic       m_out_payload_tlast;
  logic       m_out_payload_tvalid;
  logic       m_out_payload_tready;

  // Core side: consumes the input stream, produces the output stream.
  modport slave (
    input  s_in_payload_tdata, s_in_payload_tkeep, s_in_payload_tlast, s_in_payload_tvalid,
    output s_in_payload_tready,
    output m_out_payload_tdata, m_out_payload_tkeep, m_out_payload_tlast, m_out_payload_tvalid,
    input  m_out_payload_tready
  );

  modport master (
    output s_in_payload_tdata, s_in_payload_tkeep, s_in_payload_tlast, s_in_payload_tvalid,
    input  s_in_payload_tready,
    input  m_out_payload_tdata, m_out_payload_tkeep, m_out_payload_tlast, m_out_payload_tvalid,
    output m_out_payload_tready
  );
endinterface

// File: rtl/conv_encode_core.sv
// Rate-1/2 K=7 convolutional encoder core with bypass and CtrlPort registers.
// Optional zero-byte trellis tail per packet enabled by defining CONV_TAIL_EN.
module conv_encode_core #(
  parameter logic [6:0] G0 = 7'b1011011,
  parameter logic [6:0] G1 = 7'b1111001
) (
  input  logic                axis_data_clk,
  input  logic                axis_data_rst_n,
  conv_encode_core_if.slave   axis,
  input  logic                s_ctrlport_req_wr,
  input  logic                s_ctrlport_req_rd,
  input  logic [19:0]         s_ctrlport_req_addr,
  input  logic [31:0]         s_ctrlport_req_data,
  output logic                s_ctrlport_resp_ack,
  output logic [31:0]         s_ctrlport_resp_data
);

  typedef enum logic [2:0] {
    ST_EMPTY,
    ST_HI,
    ST_LO
`ifdef CONV_TAIL_EN
    ,
    ST_TAIL_HI,
    ST_TAIL_LO
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  enc_q, enc_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  lo_q, lo_d;
  logic        last_q, last_d;
  logic        sop_q, sop_d;
  logic        byp_pkt_q, byp_pkt_d;
  logic        byp_valid_q, byp_valid_d;
  logic [7:0]  byp_data_q, byp_data_d;
  logic        byp_last_q, byp_last_d;
  logic        run_q;
  logic        ctrl_q, ctrl_d;
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic        ack_q, ack_d;
  logic [31:0] resp_q, resp_d;

  logic        in_acc, out_acc, byp_eff, pend_tail;
  logic [21:0] enc_res;
  logic [31:0] rd_val;
  logic        unused_inputs;

  assign unused_inputs = &{1'b0, axis.s_in_payload_tkeep, s_ctrlport_req_data[31:1]};

  // Returns {next_state[5:0], byteA[7:0], byteB[7:0]}; bits consumed MSB first.
  function automatic logic [21:0] encode_byte(input logic [7:0] din, input logic [5:0] sin);
    logic [5:0]  s;
    logic [6:0]  w;
    logic [15:0] code;
    s    = sin;
    code = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      w                = {din[7 - i], s};
      code[15 - 2*i]   = ^(w & G0);
      code[14 - 2*i]   = ^(w & G1);
      s                = w[6:1];
    end
    return {s, code};
  endfunction

`ifdef CONV_TAIL_EN
  logic [21:0] tail_res;
  assign tail_res  = encode_byte(8'h00, enc_q);
  assign pend_tail = last_q;
`else
  assign pend_tail = 1'b0;
`endif

  // Bypass is latched at the first byte of a packet and held for the rest of it.
  assign byp_eff = sop_q ? ctrl_q : byp_pkt_q;
  assign enc_res = encode_byte(axis.s_in_payload_tdata, sop_q ? 6'd0 : enc_q);
  assign in_acc  = axis.s_in_payload_tvalid & axis.s_in_payload_tready;
  assign out_acc = axis.m_out_payload_tvalid & axis.m_out_payload_tready;

  always_comb begin
    axis.m_out_payload_tvalid = 1'b0;
    axis.m_out_payload_tdata  = '0;
    axis.m_out_payload_tlast  = 1'b0;
    axis.m_out_payload_tkeep  = 1'b1;
    axis.s_in_payload_tready  = run_q &
      (((state_q == ST_EMPTY) & (~byp_valid_q | axis.m_out_payload_tready)) |
       ((state_q == ST_LO) & axis.m_out_payload_tready & ~pend_tail));
    case (state_q)
      ST_EMPTY: begin
        axis.m_out_payload_tvalid = byp_valid_q;
        axis.m_out_payload_tdata  = byp_valid_q ? byp_data_q : '0;
        axis.m_out_payload_tlast  = byp_valid_q & byp_last_q;
      end
      ST_HI: begin
        axis.m_out_payload_tvalid = 1'b1;
        axis.m_out_payload_tdata  = hi_q;
      end
      ST_LO: begin
        axis.m_out_payload_tvalid = 1'b1;
        axis.m_out_payload_tdata  = lo_q;
`ifndef CONV_TAIL_EN
        axis.m_out_payload_tlast  = last_q;
`endif
      end
`ifdef CONV_TAIL_EN
      ST_TAIL_HI: begin
        axis.m_out_payload_tvalid = 1'b1;
        axis.m_out_payload_tdata  = hi_q;
      end
      ST_TAIL_LO: begin
        axis.m_out_payload_tvalid = 1'b1;
        axis.m_out_payload_tdata  = lo_q;
        axis.m_out_payload_tlast  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    enc_d       = enc_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    last_d      = last_q;
    sop_d       = sop_q;
    byp_pkt_d   = byp_pkt_q;
    byp_valid_d = byp_valid_q & ~axis.m_out_payload_tready;
    byp_data_d  = byp_data_q;
    byp_last_d  = byp_last_q;

    if (in_acc) begin
      sop_d = axis.s_in_payload_tlast;
      if (sop_q) byp_pkt_d = ctrl_q;
    end

    if (in_acc & byp_eff) begin
      byp_valid_d = 1'b1;
      byp_data_d  = axis.s_in_payload_tdata;
      byp_last_d  = axis.s_in_payload_tlast;
    end

    case (state_q)
      ST_EMPTY: begin
        if (in_acc & ~byp_eff) begin
          state_d = ST_HI;
          {enc_d, hi_d, lo_d} = enc_res;
          last_d  = axis.s_in_payload_tlast;
        end
      end
      ST_HI: if (out_acc) state_d = ST_LO;
      ST_LO: begin
        if (out_acc) begin
`ifdef CONV_TAIL_EN
          if (last_q) begin
            state_d = ST_TAIL_HI;
            {enc_d, hi_d, lo_d} = tail_res;
          end else
`endif
          if (in_acc & ~byp_eff) begin
            state_d = ST_HI;
            {enc_d, hi_d, lo_d} = enc_res;
            last_d  = axis.s_in_payload_tlast;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
`ifdef CONV_TAIL_EN
      ST_TAIL_HI: if (out_acc) state_d = ST_TAIL_LO;
      ST_TAIL_LO: if (out_acc) state_d = ST_EMPTY;
`endif
      default: state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    case (s_ctrlport_req_addr)
      20'h00000: rd_val = {31'd0, ctrl_q};
      20'h00004: rd_val = pkt_cnt_q;
      default:   rd_val = '0;
    endcase
    ack_d     = s_ctrlport_req_wr | s_ctrlport_req_rd;
    resp_d    = s_ctrlport_req_rd ? rd_val : '0;
    ctrl_d    = (s_ctrlport_req_wr && s_ctrlport_req_addr == 20'h00000) ?
                s_ctrlport_req_data[0] : ctrl_q;
    pkt_cnt_d = (out_acc & axis.m_out_payload_tlast) ? pkt_cnt_q + 32'd1 : pkt_cnt_q;
  end

  always_ff @(posedge axis_data_clk or negedge axis_data_rst_n) begin
    if (!axis_data_rst_n) begin
      state_q     <= ST_EMPTY;
      enc_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      last_q      <= 1'b0;
      sop_q       <= 1'b1;
      byp_pkt_q   <= 1'b0;
      byp_valid_q <= 1'b0;
      byp_data_q  <= '0;
      byp_last_q  <= 1'b0;
      run_q       <= 1'b0;
      ctrl_q      <= 1'b0;
      pkt_cnt_q   <= '0;
      ack_q       <= 1'b0;
      resp_q      <= '0;
    end else begin
      state_q     <= state_d;
      enc_q       <= enc_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      last_q      <= last_d;
      sop_q       <= sop_d;
      byp_pkt_q   <= byp_pkt_d;
      byp_valid_q <= byp_valid_d;
      byp_data_q  <= byp_data_d;
      byp_last_q  <= byp_last_d;
      run_q       <= 1'b1;
      ctrl_q      <= ctrl_d;
      pkt_cnt_q   <= pkt_cnt_d;
      ack_q       <= ack_d;
      resp_q      <= resp_d;
    end
  end

  assign s_ctrlport_resp_ack  = ack_q;
  assign s_ctrlport_resp_data = resp_q;

endmodule

// File: tb/tb_conv_encode_core.sv
// Self-checking bench for conv_encode_core: directed and random packets against a convolution-sum model.
module tb_conv_encode_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_encode_core_if axis ();
  logic        wr, rd;
  logic [19:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  conv_encode_core #(.G0(7'b1011011), .G1(7'b1111001)) dut (
    .axis_data_clk        (clk),
    .axis_data_rst_n      (rst_n),
    .axis                 (axis.slave),
    .s_ctrlport_req_wr    (wr),
    .s_ctrlport_req_rd    (rd),
    .s_ctrlport_req_addr  (addr),
    .s_ctrlport_req_data  (wdata),
    .s_ctrlport_resp_ack  (ack),
    .s_ctrlport_resp_data (rdata)
  );

  int checks = 0;
  int failures = 0;
  int exp_pkts = 0;

  logic [7:0] pkt[$];      // staging for the next packet
  logic [8:0] in_q[$];     // {last, data} to drive
  logic [9:0] exp_q[$];    // {tail_beat, last, data} expected
  logic [8:0] obs_q[$];    // {last, data} observed

`ifdef CONV_TAIL_EN
  localparam int OUT_PER_1B = 4;
  localparam logic TAIL_ON = 1'b1;
`else
  localparam int OUT_PER_1B = 2;
  localparam logic TAIL_ON = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Code bits as a convolution sum over the packet's bit sequence (octal generators 133/171).
  task automatic add_packet(input bit byp);
    int n;
    bit bits[$];
    logic [6:0] g0, g1;
    logic [7:0] ob;
    bit c0, c1;
    int total;
    n  = pkt.size();
    g0 = 7'o133;
    g1 = 7'o171;
    for (int i = 0; i < n; i++) in_q.push_back({(i == n - 1), pkt[i]});
    if (byp) begin
      for (int i = 0; i < n; i++) exp_q.push_back({1'b0, (i == n - 1), pkt[i]});
    end else begin
      for (int i = 0; i < n; i++)
        for (int b = 7; b >= 0; b--) bits.push_back(pkt[i][b]);
      if (TAIL_ON) for (int b = 0; b < 8; b++) bits.push_back(1'b0);
      total = bits.size();
      for (int k = 0; k < total; k += 4) begin
        ob = '0;
        for (int p = 0; p < 4; p++) begin
          c0 = 1'b0;
          c1 = 1'b0;
          for (int j = 0; j < 7; j++) begin
            if (k + p - j >= 0) begin
              c0 = c0 ^ (g0[6 - j] & bits[k + p - j]);
              c1 = c1 ^ (g1[6 - j] & bits[k + p - j]);
            end
          end
          ob = {ob[5:0], c0, c1};
        end
        exp_q.push_back({(k >= n * 8), (k + 4 >= total), ob});
      end
    end
    pkt.delete();
    exp_pkts++;
  endtask

  task automatic run_stream(input int rdy_pct, input int vld_pct, input int wr_at, input string tag);
    int cyc;
    bit acc, stall;
    logic [8:0] held, beat;
    logic [9:0] e;
    cyc = 0; acc = 0; stall = 0; held = '0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < 20000) begin
      @(negedge clk);
      if (acc) begin
        void'(in_q.pop_front());
        axis.s_in_payload_tvalid = 1'b0;
        acc = 0;
      end
      wr = (cyc == wr_at);
      addr = '0;
      wdata = 32'd1;
      if (!axis.s_in_payload_tvalid && in_q.size() > 0 && $urandom_range(99) < vld_pct) begin
        axis.s_in_payload_tvalid = 1'b1;
        axis.s_in_payload_tdata  = in_q[0][7:0];
        axis.s_in_payload_tlast  = in_q[0][8];
      end
      axis.m_out_payload_tready = ($urandom_range(99) < rdy_pct);
      #1;
      beat = {axis.m_out_payload_tlast, axis.m_out_payload_tdata};
      if (stall) chk({tag, " stall_hold"}, {22'd0, axis.m_out_payload_tvalid, beat}, {22'd0, 1'b1, held});
      if (axis.m_out_payload_tvalid && axis.m_out_payload_tready) begin
        if (exp_q.size() == 0) begin
          chk({tag, " extra_beat"}, {23'd0, beat}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          if (e[9]) chk({tag, " tail_tready"}, {31'd0, axis.s_in_payload_tready}, 32'd0);
          chk({tag, " beat"}, {23'd0, beat}, {23'd0, e[8:0]});
          obs_q.push_back(beat);
        end
      end
      stall = axis.m_out_payload_tvalid && !axis.m_out_payload_tready;
      held  = beat;
      acc   = axis.s_in_payload_tvalid && axis.s_in_payload_tready;
      cyc++;
    end
    @(negedge clk);
    if (acc) begin
      void'(in_q.pop_front());
      axis.s_in_payload_tvalid = 1'b0;
    end
    wr = 1'b0;
    axis.m_out_payload_tready = 1'b0;
    chk({tag, " drained"}, in_q.size() + exp_q.size(), 32'd0);
  endtask

  task automatic ctrl_access(input bit w, input bit r, input logic [19:0] a,
                             input logic [31:0] d, output logic [31:0] q);
    @(negedge clk);
    wr = w; rd = r; addr = a; wdata = d;
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    chk("ctrl_ack", {31'd0, ack}, 32'd1);
    q = rdata;
    @(negedge clk);
    chk("ctrl_ack_drop", {31'd0, ack}, 32'd0);
    chk("ctrl_resp_idle", rdata, 32'd0);
  endtask

  task automatic read_expect(input logic [19:0] a, input logic [31:0] expv, input string tag);
    logic [31:0] q;
    ctrl_access(1'b0, 1'b1, a, 32'd0, q);
    chk(tag, q, expv);
  endtask

  logic [31:0] q;
  int len;

  initial begin
    wr = 0; rd = 0; addr = '0; wdata = '0;
    axis.s_in_payload_tdata = '0; axis.s_in_payload_tkeep = 1'b1;
    axis.s_in_payload_tlast = 1'b0; axis.s_in_payload_tvalid = 1'b0;
    axis.m_out_payload_tready = 1'b0;

    // Reset state
    #12;
    chk("rst_tvalid", {31'd0, axis.m_out_payload_tvalid}, 32'd0);
    chk("rst_tdata", {24'd0, axis.m_out_payload_tdata}, 32'd0);
    chk("rst_tlast", {31'd0, axis.m_out_payload_tlast}, 32'd0);
    chk("rst_tkeep", {31'd0, axis.m_out_payload_tkeep}, 32'd1);
    chk("rst_tready", {31'd0, axis.s_in_payload_tready}, 32'd0);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_resp", rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_tready_low", {31'd0, axis.s_in_payload_tready}, 32'd0);
    @(negedge clk);
    chk("rel_tready_high", {31'd0, axis.s_in_payload_tready}, 32'd1);
    read_expect(20'h00000, 32'd0, "rst_reg_ctrl");
    read_expect(20'h00004, 32'd0, "rst_pkt_count");

    // Impulse
    obs_q.delete();
    pkt.push_back(8'h80); add_packet(0);
    run_stream(100, 100, -1, "impulse");
    chk("impulse_len", obs_q.size(), OUT_PER_1B);
    if (obs_q.size() >= 2) begin
      chk("impulse_A", {23'd0, obs_q[0]}, {23'd0, 1'b0, 8'hDF});
      chk("impulse_B", {23'd0, obs_q[1]}, {23'd0, ~TAIL_ON, 8'h2C});
    end
    if (TAIL_ON && obs_q.size() >= 4) begin
      chk("impulse_T0", {23'd0, obs_q[2]}, {23'd0, 9'h000});
      chk("impulse_T1", {23'd0, obs_q[3]}, {23'd0, 9'h100});
    end
    read_expect(20'h00004, 32'd1, "impulse_pkt_count");

    // State cleared at packet boundary
    obs_q.delete();
    pkt.push_back(8'h80); add_packet(0);
    pkt.push_back(8'h00); add_packet(0);
    run_stream(100, 100, -1, "b2b");
    chk("b2b_len", obs_q.size(), 2 * OUT_PER_1B);
    if (obs_q.size() >= OUT_PER_1B + 2) begin
      chk("b2b_second_A", {23'd0, obs_q[OUT_PER_1B]}, 32'h000);
      chk("b2b_second_B", {23'd0, obs_q[OUT_PER_1B + 1]}, {23'd0, ~TAIL_ON, 8'h00});
    end

    // Random packets under 50% backpressure
    for (int p = 0; p < 64; p++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) pkt.push_back(8'($urandom_range(255)));
      add_packet(0);
    end
    run_stream(50, 70, -1, "bp");
    read_expect(20'h00004, exp_pkts, "bp_pkt_count");

    // Register map corners
    ctrl_access(1'b1, 1'b1, 20'h00000, 32'd1, q);
    chk("wr_rd_old", q, 32'd0);
    read_expect(20'h00000, 32'd1, "wr_rd_new");
    ctrl_access(1'b1, 1'b0, 20'h00000, 32'd0, q);
    ctrl_access(1'b1, 1'b0, 20'h00008, 32'hDEAD_BEEF, q);
    read_expect(20'h00008, 32'd0, "unmapped_read");
    read_expect(20'h00000, 32'd0, "unmapped_no_alias");

    // Bypass written mid-packet: current packet stays encoded, next passes through
    obs_q.delete();
    pkt.push_back(8'hA5); pkt.push_back(8'h3C); pkt.push_back(8'h7E); add_packet(0);
    pkt.push_back(8'h12); pkt.push_back(8'h34); add_packet(1);
    run_stream(100, 100, 2, "bypass");
    if (obs_q.size() >= 2) begin
      chk("bypass_first", {23'd0, obs_q[obs_q.size() - 2]}, 32'h012);
      chk("bypass_last", {23'd0, obs_q[obs_q.size() - 1]}, 32'h134);
    end
    read_expect(20'h00000, 32'd1, "bypass_reg_ctrl");
    read_expect(20'h00004, exp_pkts, "bypass_pkt_count");
    ctrl_access(1'b1, 1'b0, 20'h00000, 32'd0, q);

    // Asynchronous reset while byte A is pending
    @(negedge clk);
    axis.s_in_payload_tvalid = 1'b1;
    axis.s_in_payload_tdata  = 8'h80;
    axis.s_in_payload_tlast  = 1'b0;
    axis.m_out_payload_tready = 1'b0;
    #1 chk("ar_accept", {31'd0, axis.s_in_payload_tready}, 32'd1);
    @(negedge clk);
    axis.s_in_payload_tvalid = 1'b0;
    #1;
    chk("ar_hi_valid", {31'd0, axis.m_out_payload_tvalid}, 32'd1);
    chk("ar_hi_data", {24'd0, axis.m_out_payload_tdata}, 32'hDF);
    ctrl_access(1'b1, 1'b0, 20'h00000, 32'd1, q);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_tvalid", {31'd0, axis.m_out_payload_tvalid}, 32'd0);
    chk("ar_tdata", {24'd0, axis.m_out_payload_tdata}, 32'd0);
    chk("ar_tready", {31'd0, axis.s_in_payload_tready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar_rel_tready", {31'd0, axis.s_in_payload_tready}, 32'd1);
    chk("ar_rel_tvalid", {31'd0, axis.m_out_payload_tvalid}, 32'd0);
    read_expect(20'h00000, 32'd0, "ar_reg_ctrl");
    read_expect(20'h00004, 32'd0, "ar_pkt_count");
    exp_pkts = 0;

    obs_q.delete();
    pkt.push_back(8'h00); add_packet(0);
    run_stream(100, 100, -1, "post_reset");
    chk("post_reset_len", obs_q.size(), OUT_PER_1B);
    read_expect(20'h00004, exp_pkts, "post_reset_pkt_count");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/conv_encode_core.md
# conv_encode_core

Rate-1/2, K=7 convolutional encoder core for the conv RFNoC block. It sits directly downstream of the block's NoC shell and consumes the 8-bit input payload stream. It returns two coded bytes per input byte to the shell's output payload stream. A small CtrlPort register file provides bypass control and an output-packet counter. Context streams are wired around this core by the block top level and do not pass through it.

## Interface
Parameters:
- G0, 7'b1011011, generator polynomial 0 (octal 133); bit 6 taps the current input bit.
- G1, 7'b1111001, generator polynomial 1 (octal 171).

Ports:
- axis_data_clk  in  1  block clock; all logic is in this domain.
- axis_data_rst_n  in  1  asynchronous active-low reset. Assertion is asynchronous; release must be synchronous to axis_data_clk.
- s_in_payload_tdata/tkeep/tlast/tvalid  in  8/1/1/1  input byte stream. tkeep is ignored.
- s_in_payload_tready  out  1  input ready.
- m_out_payload_tdata/tkeep/tlast/tvalid  out  8/1/1/1  coded byte stream. tkeep is constant 1.
- m_out_payload_tready  in  1  output ready.
- s_ctrlport_req_wr, s_ctrlport_req_rd  in  1  CtrlPort request strobes.
- s_ctrlport_req_addr  in  20  byte address.
- s_ctrlport_req_data  in  32  write data.
- s_ctrlport_resp_ack  out  1  response acknowledge.
- s_ctrlport_resp_data  out  32  read data.

## Operation
- Encoder state s[5:0] is cleared to 0 at the first byte of every packet.
- Input bits are consumed MSB first. For each bit u, form window w = {u, s}, where w[6] = u and w[0] = oldest bit.
  - c0 = ^(w & G0), c1 = ^(w & G1).
  - Next state s = w[6:1].
- The four (c0,c1) pairs from bits 7..4 form output byte A, with bit 7's pair in A[7:6]. Bits 3..0 form byte B in the same way. Byte A is emitted before byte B.
- Output FSM states:
  - EMPTY: no output pending.
  - HI: byte A valid.
  - LO: byte B valid.
  - TAIL_HI / TAIL_LO: present only with CONV_TAIL_EN.
- FSM transitions:
  - EMPTY→HI on input accept.
  - HI→LO on output accept.
  - LO→EMPTY on output accept, or LO→HI if a new byte is accepted in the same cycle.
  - If the encoded byte had tlast: LO→TAIL_HI (with tail enabled) or LO→EMPTY.
- s_in_payload_tready = (EMPTY) | (LO & m_out_payload_tready & !last_pending_tail).
- m_out_payload_tlast is set only on the final output byte of a packet.
- Bypass (REG_CTRL bit 0 = 1):
  - Bytes pass 1:1 through a single output register with tlast preserved; the state machine is unused.
  - The bypass bit is sampled only at a packet start. A change mid-packet takes effect at the next packet.
- Registers (other addresses read 0; writes to them are ignored):
  - 0x00 REG_CTRL: RW. Bit 0 = bypass.
  - 0x04 REG_PKT_COUNT: RO. Increments on each accepted output beat with tlast; wraps from 0xFFFFFFFF to 0.
- If wr and rd are asserted together, the write is performed and the read returns the old value.

## Timing
- Reset values: all outputs 0 (tvalid, tdata, tlast, tready, resp_ack, resp_data); tkeep = 1. FSM = EMPTY, s = 0, REG_CTRL = 0, REG_PKT_COUNT = 0.
- s_in_payload_tready rises in the first cycle after reset release.
- Latency:
  - Byte A is valid in the cycle after the input accept.
  - Byte B is valid in the cycle after byte A is accepted.
- Throughput: with continuous tready, one input byte every 2 cycles and one output byte every cycle, with no bubbles across packet boundaries.
- Once asserted, m_out_payload_tvalid and tdata hold stable until accepted.
- CtrlPort: s_ctrlport_resp_ack pulses for 1 cycle, exactly one cycle after a request. resp_data is valid with ack and 0 otherwise.
- A reset asserted mid-packet discards all pending output immediately. No partial packet is resumed.

## Configuration
- CONV_TAIL_EN defined:
  - After the tlast input byte, encode one extra 0x00 tail byte. This gives two more output bytes (TAIL_HI, TAIL_LO).
  - tlast moves to TAIL_LO; input is not ready during the tail states.
  - Output length is 2N+2 bytes per N-byte packet.
  - Bypass packets get no tail.
- CONV_TAIL_EN undefined: no tail states. Output length is 2N bytes; tlast is on the LO byte of the last input byte.

## Test plan
- Impulse, tail off: 1-byte packet 0x80 → output 0xDF, 0x2C (tlast on 0x2C). REG_PKT_COUNT reads 1.
- Impulse, CONV_TAIL_EN: 0x80 → 0xDF, 0x2C, 0x00, 0x00 (tlast on 4th byte). Input tready is 0 for the two tail beats.
- State reset at packet boundary: packets [0x80] then [0x00], back-to-back → second packet outputs 0x00, 0x00, with no carry-over from the first.
- Backpressure: random m_out_payload_tready (50%) over 64 random packets → output matches the reference model bit-exactly, and tdata/tvalid stay stable while stalled.
- Bypass: write REG_CTRL = 1 mid-packet → the current packet stays encoded. The next packet [0x12, 0x34] outputs 0x12, 0x34 (tlast on 0x34).
- Async reset: assert axis_data_rst_n low during HI → m_out_payload_tvalid is 0 in the same cycle and REG_CTRL reads 0 after release.
